imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
// - Parametrised, pipelined immediate extender for the MIPS datapath. Sits between the instruction-decode
//   field split and the ALU-B / branch-target mux.
// - Takes an IN_W-bit immediate plus a mode, produces an OUT_W-bit operand. Modes: sign, zero, upper (LUI),
//   branch-shifted.
// - valid/ready on both sides; internal DEPTH-entry output FIFO absorbs downstream stalls without dropping data.
// PARAMETERS
// - IN_W      16  immediate input width; 1 <= IN_W < OUT_W
// - OUT_W     32  extended output width
// - DEPTH     2   output FIFO entries; >= 1
// - BR_SHIFT  2   left-shift amount applied in mode 2'b11; 0 <= BR_SHIFT < OUT_W
// PORTS
// - Clk        in   1                   clock; all state updates on rising edge
// - Reset_n    in   1                   asynchronous, active-low reset
// - in_valid   in   1                   in_imm / in_mode are valid this cycle
// - in_ready   out  1                   block accepts input this cycle
// - in_imm     in   IN_W                raw immediate field
// - in_mode    in   2                   00 sign, 01 zero, 10 upper, 11 sign-then-shift
// - out_valid  out  1                   out_data holds a valid result
// - out_ready  in   1                   downstream consumes out_data this cycle
// - out_data   out  OUT_W               extended result (FIFO head)
// - occupancy  out  $clog2(DEPTH+1)     entries currently held
// BEHAVIOUR
// - Reset_n low (asynchronous, any cycle, mid-transfer included): FIFO flushed, occupancy=0, out_valid=0,
//   out_data=0. In-flight data is discarded and not replayed.
// - in_ready = (occupancy < DEPTH), driven from registered state only; no combinational path from out_ready.
//   It is therefore 1 during and after reset.
// - Accept (push) when in_valid && in_ready. Pop when out_valid && out_ready.
// - Latency: an input accepted at edge N with FIFO empty is visible on out_data with out_valid=1 after edge N
//   (1 cycle). Back-to-back accepts sustain 1 result/cycle while out_ready=1.
// - Arithmetic, with E = OUT_W-IN_W:
//   - 00 sign:  {{E{in_imm[IN_W-1]}}, in_imm}
//   - 01 zero:  {{E{1'b0}}, in_imm}
//   - 10 upper: in_imm placed at bits [OUT_W-1 -: IN_W] (i.e. in_imm << E, truncated to OUT_W).
//     When IN_W < E, zero-fill below.
//   - 11 br:    (sign-extended value) << BR_SHIFT, truncated to OUT_W. Bits shifted past MSB are lost;
//     no overflow flag.
// - The result is computed at push time and stored. The stored value does not depend on later in_mode/in_imm.
// - FIFO: circular, read/write pointers wrap at DEPTH (DEPTH need not be a power of 2). Order is strictly FIFO.
// - Simultaneous push and pop:
//   - 0 < occupancy < DEPTH: occupancy unchanged, both succeed.
//   - occupancy == DEPTH: in_ready=0, so only the pop occurs (occupancy-1); in_ready rises next cycle.
//   - occupancy == 0: no pop possible (out_valid=0); push only.
// - Empty: out_valid=0, out_data=0. Non-empty: out_data = head entry, stable until popped.
// - Input with in_valid=1 while in_ready=0 is ignored; upstream must hold it.
// - occupancy changes only on Clk edges or reset; it never exceeds DEPTH.
// TESTING
// - Modes, defaults, out_ready=1:
//   - 16'h8001/00 -> 32'hFFFF8001
//   - 16'h8001/01 -> 32'h00008001
//   - 16'h1234/10 -> 32'h12340000
//   - 16'hFFFF/11 -> 32'hFFFFFFFC
//   Each appears 1 cycle after accept.
// - Backpressure, DEPTH=2:
//   - out_ready=0; push 16'h0001, 16'h0002, 16'h0003 on consecutive cycles.
//   - Third is held off (in_ready=0, occupancy=2).
//   - Release out_ready: outputs 1, 2, then 3 in order. No loss, no duplicate.
// - Full + simultaneous: occupancy=2, in_valid=1, out_ready=1 -> pop only that cycle (occupancy=1);
//   the push lands on the next cycle.
// - Streaming: 8 consecutive sign-mode inputs with out_ready=1 -> 8 outputs on 8 consecutive cycles;
//   pointers wrap cleanly.
// - Reset mid-operation: occupancy=2, assert Reset_n=0 between edges -> out_valid/out_data/occupancy go to 0
//   immediately. After release, first new input 16'h7FFF/00 -> 32'h00007FFF.
// - Param sweep: IN_W=8, OUT_W=16, BR_SHIFT=1, DEPTH=3.
//   - 8'h80/00 -> 16'hFF80
//   - 8'h80/10 -> 16'h8000
//   - 8'hC0/11 -> 16'hFF80

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender for the MIPS datapath.
// The input immediate is extended according to in_mode when it is accepted.
// The result then waits in a small circular FIFO until the ALU-B or
// branch-target consumer takes it. in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int DEPTH    = 2,
    parameter int BR_SHIFT = 2
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_imm,
    input  logic [1:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int E  = OUT_W - IN_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR_C = PW'(DEPTH - 1);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_d;

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign occupancy = count_q;
    // An empty FIFO presents zero so that stale entries never leak out.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Extend the immediate once, at push time. The branch mode reuses the
    // sign-extended value, and bits shifted past the MSB are dropped.
    always_comb begin
        sext = {{E{in_imm[IN_W-1]}}, in_imm};
        case (in_mode)
            2'b00:   ext_d = sext;
            2'b01:   ext_d = {{E{1'b0}}, in_imm};
            2'b10:   ext_d = {in_imm, {E{1'b0}}};
            default: ext_d = sext << BR_SHIFT;
        endcase
    end

    // Next pointers and count. The pointers wrap at DEPTH, which need not be
    // a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR_C) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR_C) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state. Reset flushes the FIFO immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage for each entry. Entries need no reset because out_data is
    // gated by occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the extended value into the slot the write pointer selects.
            always_ff @(posedge Clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= ext_d;
                end
            end
        end
    endgenerate

endmodule
